dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder for the pipelined CPU's MEM stage. It accepts one load or store request at a time from the EXMEM pipeline register and holds the pipeline with a stall while the access completes. After a programmable latency it completes the access against an internal word array and returns an acknowledge with read data. It replaces the single-cycle data memory, so the pipeline can be run against realistic memory latency.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words in the array; word index is addr_i[31:2]
- LATENCY, 4, cycles from request acceptance to ack_o; legal range 1..15
- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  reset, synchronous and active-high
- req_i  input  1  access request: MemRead or MemWrite from EXMEM
- we_i  input  1  1 = store, 0 = load; valid with req_i
- addr_i  input  32  byte address (EXMEM ALU result)
- wdata_i  input  32  store data
- stall_o  output  1  pipeline hold; drives PC, IFID, IDEX and EXMEM stall/write-enable
- ack_o  output  1  one-cycle completion pulse
- rdata_o  output  32  load data, valid only while ack_o=1
- err_o  output  1  with ack_o: misaligned or out-of-range access

## Operation
- States: IDLE, BUSY, DONE, ERR; the array `memory[0:DEPTH_WORDS-1]` is not reset and is preloaded by the bench.
- IDLE, req_i=1, addr_i[1:0]!=0 or addr_i[31:2]>=DEPTH_WORDS: go to ERR; no array access.
- IDLE, req_i=1, legal address: latch addr/we/wdata.
  - LATENCY=1: go to DONE and perform the access on that edge.
  - Otherwise: load counter with LATENCY-2 and go to BUSY.
- IDLE, req_i=0: stay in IDLE.
- BUSY, req_i=0: abort; return to IDLE with no write and no ack.
- BUSY, counter != 0: decrement the counter.
- BUSY, counter = 0: perform the latched access on this edge and go to DONE.
  - Store: write wdata to memory[idx].
  - Load: rdata register <= memory[idx].
- DONE: ack_o=1; rdata_o = loaded word (0 for stores); err_o=0; next state IDLE unconditionally.
- ERR: ack_o=1, err_o=1, rdata_o=0; next state IDLE.
- stall_o = req_i & ~ack_o, combinational. It is high during the IDLE-accept cycle and throughout BUSY, and low in DONE/ERR so the pipeline advances on that edge.
- Requester rules:
  - Hold req_i, we_i, addr_i and wdata_i stable while stall_o=1.
  - Changes to we_i, addr_i or wdata_i after acceptance are ignored, because the latched copies are used.
- Simultaneous store then load to the same word: the load issues after DONE, so it sees the stored value. No bypass is needed.

## Timing
- Reset: state IDLE, counter 0, ack_o=0, err_o=0, rdata_o=0.
  - stall_o follows req_i (combinational) from the first cycle after reset.
  - Reset during BUSY or DONE discards the pending access; no write occurs.
  - Reset has priority over all transitions.
- Latency: request sampled in cycle 0; ack_o high in cycle LATENCY.
  - The request is stalled for LATENCY cycles (cycles 0..LATENCY-1).
  - An error ack arrives in cycle 1.
- Throughput: one access per LATENCY+1 cycles. The new request is sampled in the cycle after DONE, which is IDLE.
- rdata_o is registered and changes only on the edge entering DONE or leaving DONE (leaving returns it to 0).
- ack_o is never high in two consecutive cycles.
- Counter width is 4 bits; there is no wrap-around because the counter stops at 0.

## Test plan
- Reset with req_i=1 -> ack_o=0, rdata_o=0, err_o=0; stall_o=1; after reset deasserts, the first ack arrives exactly LATENCY cycles after the first sampled cycle.
- LATENCY=4, load addr 0x10 with memory[4]=0xDEADBEEF -> stall_o high cycles 0-3; ack_o=1 and rdata_o=0xDEADBEEF in cycle 4 only; stall_o=0 in cycle 4.
- Store 0x12345678 to 0x20, then back-to-back load of 0x20 -> second ack returns 0x12345678, 5 cycles after the first ack.
- Load at 0x22 (misaligned) and at 0x1000 with DEPTH_WORDS=1024 -> ack_o=err_o=1 in cycle 1, rdata_o=0, array unchanged.
- Store to 0x30 with req_i dropped in BUSY cycle 2 -> no ack, memory[12] unchanged; state back to IDLE and the next request is serviced normally.
- LATENCY=1, alternating stores and loads to 0x0..0xC -> ack every 2nd cycle, each load returns the prior store's data; rst_i pulsed mid-BUSY (LATENCY=4) -> store suppressed.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the CPU MEM stage.
// Accepts one load/store at a time, stalls the pipeline for LATENCY cycles,
// then completes the access against an internal word array and pulses ack.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0]       count;
  logic [3:0]       count_next;
  logic             we_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;

  logic [31:0] memory [0:DEPTH_WORDS-1];

  logic             addr_bad;
  logic [IDX_W-1:0] idx_in;
  logic             latch;
  logic             do_access;
  logic             acc_we;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      acc_wdata;

  assign addr_bad = (addr_i[1:0] != 2'b00) ||
                    ({2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS));
  assign idx_in   = addr_i[IDX_W+1:2];

  // Next-state logic; also selects which address/data the access uses this edge
  always_comb begin
    state_next = state;
    count_next = count;
    latch      = 1'b0;
    do_access  = 1'b0;
    acc_we     = we_q;
    acc_idx    = idx_q;
    acc_wdata  = wdata_q;
    case (state)
      IDLE: begin
        if (req_i) begin
          if (addr_bad) begin
            state_next = ERR;
          end else begin
            latch = 1'b1;
            if (LATENCY == 1) begin
              state_next = DONE;
              do_access  = 1'b1;
              acc_we     = we_i;
              acc_idx    = idx_in;
              acc_wdata  = wdata_i;
            end else begin
              state_next = BUSY;
              count_next = 4'(LATENCY - 2);
            end
          end
        end
      end
      BUSY: begin
        if (!req_i) begin
          state_next = IDLE;
          count_next = 4'd0;
        end else if (count != 4'd0) begin
          count_next = count - 4'd1;
        end else begin
          do_access  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, latency counter and latched request registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      count   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (latch) begin
        we_q    <= we_i;
        idx_q   <= idx_in;
        wdata_q <= wdata_i;
      end
    end
  end

  // Load data register: captured entering DONE, cleared leaving DONE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= 32'd0;
    end else if (do_access) begin
      rdata_q <= acc_we ? 32'd0 : memory[acc_idx];
    end else if (state == DONE) begin
      rdata_q <= 32'd0;
    end
  end

  // Word array write port; reset suppresses any pending store
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_access && acc_we) begin
      memory[acc_idx] <= acc_wdata;
    end
  end

  assign ack_o   = (state == DONE) || (state == ERR);
  assign err_o   = (state == ERR);
  assign rdata_o = rdata_q;
  assign stall_o = req_i & ~ack_o;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with LATENCY=4 and one with
// LATENCY=1. Drivers push expected acks; a negedge monitor pops and compares.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];

  logic        stall0, ack0, err0;
  logic [31:0] rdata0;
  logic        stall1, ack1, err1;
  logic [31:0] rdata1;

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;
  logic [1:0] prev_ack = 2'b00;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) dut (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]),
    .stall_o(stall0), .ack_o(ack0), .rdata_o(rdata0), .err_o(err0)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]),
    .stall_o(stall1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1)
  );

  // Cycle counter; stable when sampled on the falling edge
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic getStall(input int i);
    return (i == 0) ? stall0 : stall1;
  endfunction

  function automatic logic getAck(input int i);
    return (i == 0) ? ack0 : ack1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge: drives a request, books its ack, tracks stall
  task automatic issueRequest(input int i, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] exp_rd,
                              input logic exp_err);
    int   lat;
    exp_t e;
    lat = exp_err ? 1 : ((i == 0) ? 4 : 1);
    req[i]   = 1'b1;
    we[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    e.rdata  = exp_rd;
    e.err    = exp_err;
    e.cyc    = cyc + lat;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("stall dut%0d addr 0x%08h +%0d", i, a, k),
            {31'b0, getStall(i)}, {31'b0, (k < lat)});
    end
  endtask

  task automatic applyStimulus(input int i, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] exp_rd,
                               input logic exp_err);
    @(negedge clk);
    issueRequest(i, w, a, d, exp_rd, exp_err);
  endtask

  task automatic idle(input int i, input int n);
    repeat (n) begin
      @(negedge clk);
      req[i] = 1'b0;
    end
  endtask

  // Pops the scoreboard whenever an instance acknowledges
  task automatic checkOutput(input int i);
    logic        a;
    logic [31:0] rd;
    logic        er;
    exp_t        e;
    a  = getAck(i);
    rd = (i == 0) ? rdata0 : rdata1;
    er = (i == 0) ? err0 : err1;
    if (a) begin
      check($sformatf("ack spacing dut%0d", i), {31'b0, prev_ack[i]}, 32'd0);
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL unexpected ack dut%0d: got ack=1, expected none (cycle %0d)", i, cyc);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("rdata dut%0d", i), rd, e.rdata);
        check($sformatf("err dut%0d", i), {31'b0, er}, {31'b0, e.err});
        check($sformatf("ack cycle dut%0d", i), 32'(cyc), 32'(e.cyc));
      end
    end
    prev_ack[i] = a;
  endtask

  // Monitor runs every falling edge, away from the active clock edge
  always @(negedge clk) begin
    checkOutput(0);
    checkOutput(1);
  end

  logic [31:0] pat [4];

  initial begin
    pat[0] = 32'hC0DE_0001;
    pat[1] = 32'h0BAD_CAFE;
    pat[2] = 32'hFEED_0003;
    pat[3] = 32'h1357_9BDF;
    rst = 2'b11;
    req = 2'b00;
    we  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i]  = 32'd0;
      wdata[i] = 32'd0;
    end

    // Reset held with a request pending
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset ack", {31'b0, ack0}, 32'd0);
    check("reset err", {31'b0, err0}, 32'd0);
    check("reset rdata", rdata0, 32'd0);
    check("reset stall", {31'b0, stall0}, 32'd1);

    // Release reset; first ack exactly LATENCY cycles later
    @(negedge clk);
    rst = 2'b00;
    issueRequest(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
    applyStimulus(0, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);

    // Store then back-to-back load of the same word
    applyStimulus(0, 1'b1, 32'h20, 32'h1234_5678, 32'd0, 1'b0);
    applyStimulus(0, 1'b0, 32'h20, 32'd0, 32'h1234_5678, 1'b0);

    // Misaligned and out-of-range accesses leave the array alone
    applyStimulus(0, 1'b1, 32'h0, 32'h0BAD_F00D, 32'd0, 1'b0);
    applyStimulus(0, 1'b0, 32'h22, 32'd0, 32'd0, 1'b1);
    applyStimulus(0, 1'b0, 32'h1000, 32'd0, 32'd0, 1'b1);
    applyStimulus(0, 1'b1, 32'h22, 32'hFFFF_FFFF, 32'd0, 1'b1);
    applyStimulus(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 32'd0, 1'b1);
    applyStimulus(0, 1'b0, 32'h20, 32'd0, 32'h1234_5678, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 32'd0, 32'h0BAD_F00D, 1'b0);

    // Abort: request dropped in the second BUSY cycle
    applyStimulus(0, 1'b1, 32'h30, 32'hA5A5_A5A5, 32'd0, 1'b0);
    idle(0, 2);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'h9999_9999;
    @(negedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    applyStimulus(0, 1'b0, 32'h30, 32'd0, 32'hA5A5_A5A5, 1'b0);

    // Reset on the edge that would commit a store
    applyStimulus(0, 1'b1, 32'h34, 32'h5A5A_5A5A, 32'd0, 1'b0);
    idle(0, 1);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h34; wdata[0] = 32'h7777_7777;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    req[0] = 1'b0;
    applyStimulus(0, 1'b0, 32'h34, 32'd0, 32'h5A5A_5A5A, 1'b0);
    idle(0, 2);

    // LATENCY=1 instance: alternating stores and loads, ack every other cycle
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 1'b1, 32'(4 * k), pat[k], 32'd0, 1'b0);
      applyStimulus(1, 1'b0, 32'(4 * k), 32'd0, pat[k], 1'b0);
    end
    applyStimulus(1, 1'b0, 32'h2, 32'd0, 32'd0, 1'b1);
    applyStimulus(1, 1'b0, 32'h8, 32'd0, pat[2], 1'b0);
    idle(1, 4);

    check("dut0 acks outstanding", 32'(q0.size()), 32'd0);
    check("dut1 acks outstanding", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
